// File: rtl/key_rx.sv
// ---------------------------------------------------------------------------
// key_rx
//
// Serial receiver for the single-wire key channel. Recovers a KEY_WIDTH-bit
// word from an asynchronous, idle-high line and presents it as a parallel
// word together with a one-cycle valid strobe. Frames whose start bit turns
// out to be a glitch, or whose stop bit is low, are flagged instead.
//
// Frame on the wire: start bit (0), KEY_WIDTH data bits LSB first, stop
// bit (1). Every bit lasts BIT_CYCLES clock cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low (0 = in reset)
//   ant_in     serial line, asynchronous to clk, idle high
//   key_out    last correctly received key, bit 0 = first data bit on wire
//   key_valid  one-cycle pulse when key_out is updated
//   frame_err  one-cycle pulse on a start glitch or a bad stop bit
//   busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module key_rx #(
    parameter int KEY_WIDTH  = 256,
    parameter int BIT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ant_in,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(KEY_WIDTH + 1);

    // Half a bit period from the start edge lands in the middle of the start
    // bit; from then on every full period lands in the middle of a bit.
    localparam logic [CW-1:0] C_HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(KEY_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_rxS;
    logic                   r_rxD;
    logic [CW-1:0]          r_cycleCnt;
    logic [BW-1:0]          r_bitCnt;
    logic [KEY_WIDTH-1:0]   r_shift;
    logic [KEY_WIDTH-1:0]   r_keyOut;
    logic                   r_keyValid;
    logic                   r_frameErr;
    logic                   r_busy;

    logic                   w_fallEdge;
    logic                   w_bitTick;

    // Two-flop synchronizer for the asynchronous line plus one extra flop
    // holding the previous synchronized value for falling-edge detection.
    // All three reset to the idle level so leaving reset never looks like
    // a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_rxS   <= 1'b1;
            r_rxD   <= 1'b1;
        end else begin
            r_sync1 <= ant_in;
            r_rxS   <= r_sync1;
            r_rxD   <= r_rxS;
        end
    end

    assign w_fallEdge = r_rxD & ~r_rxS;
    assign w_bitTick  = (r_cycleCnt == C_BIT_LAST);

    // Receive state machine. Strobes default low every cycle so key_valid
    // and frame_err can only ever be single-cycle pulses, and they are set
    // in mutually exclusive branches. busy is registered alongside each
    // state transition so it always matches the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cycleCnt <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_keyOut   <= '0;
            r_keyValid <= 1'b0;
            r_frameErr <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_keyValid <= 1'b0;
            r_frameErr <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_fallEdge) begin
                        r_state    <= START;
                        r_cycleCnt <= '0;
                        r_busy     <= 1'b1;
                    end
                end

                // Confirm the start bit in its middle; a line already back
                // high by then was only a glitch.
                START: begin
                    if (r_cycleCnt == C_HALF_LAST) begin
                        if (!r_rxS) begin
                            r_state    <= DATA;
                            r_cycleCnt <= '0;
                            r_bitCnt   <= '0;
                        end else begin
                            r_state    <= IDLE;
                            r_frameErr <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end else begin
                        r_cycleCnt <= r_cycleCnt + CW'(1);
                    end
                end

                // Data arrives LSB first, so each new bit enters at the top
                // and the first bit ends up at bit 0 after KEY_WIDTH shifts.
                DATA: begin
                    if (w_bitTick) begin
                        r_cycleCnt <= '0;
                        r_shift    <= {r_rxS, r_shift[KEY_WIDTH-1:1]};
                        r_bitCnt   <= r_bitCnt + BW'(1);
                        if (r_bitCnt == C_DATA_LAST) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cycleCnt <= r_cycleCnt + CW'(1);
                    end
                end

                // Returning to IDLE at mid-stop leaves half a bit period to
                // catch the start edge of a back-to-back frame.
                STOP: begin
                    if (w_bitTick) begin
                        r_cycleCnt <= '0;
                        if (r_rxS) begin
                            r_keyOut   <= r_shift;
                            r_keyValid <= 1'b1;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_state    <= WAIT_HIGH;
                        end
                    end else begin
                        r_cycleCnt <= r_cycleCnt + CW'(1);
                    end
                end

                // A line stuck low after a bad stop bit must not be read as
                // a string of new start bits, so wait for it to go idle.
                WAIT_HIGH: begin
                    if (r_rxS) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_out   = r_keyOut;
    assign key_valid = r_keyValid;
    assign frame_err = r_frameErr;
    assign busy      = r_busy;

endmodule

// File: doc/key_rx.md
Name: key_rx

Overview:
- Serial receiver for the single-wire key channel driven by the transmit block's Ant1 output.
- Recovers a KEY_WIDTH-bit word from an asynchronous 1-bit line (idle high) and presents it as a parallel word with a one-cycle valid strobe.
- Frames with a bad start or stop bit are flagged.
- Sits at the far end of the link and feeds key capture/compare logic.

Parameters:
- KEY_WIDTH, 256, number of data bits per frame.
- BIT_CYCLES, 16, clk cycles per bit period. Must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- ant_in  input  1  serial line. Asynchronous to clk; idle = 1.
- key_out  output  KEY_WIDTH  last correctly received key. Bit 0 is the first data bit on the wire.
- key_valid  output  1  one-cycle pulse when key_out updates.
- frame_err  output  1  one-cycle pulse on start glitch or bad stop bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Frame format (fixed):
  - Start bit 0.
  - KEY_WIDTH data bits, LSB first.
  - Stop bit 1.
  - Each bit is held for BIT_CYCLES clk cycles.
- Input sync:
  - ant_in passes through a 2-flop synchronizer, reset to 1; its output is rx_s.
  - A third flop holds rx_d (previous rx_s), for edge detection.
- Reset (reset=0, asynchronous):
  - state=IDLE; bit counter and cycle counter = 0; shift register = 0.
  - key_out=0, key_valid=0, frame_err=0, busy=0; sync flops = 1.
  - Reset mid-frame discards the partial frame; key_out returns to 0.
- IDLE:
  - When rx_d=1 and rx_s=0 (falling edge): go to START and clear cycle_cnt.
- START:
  - cycle_cnt increments each cycle.
  - At cycle_cnt = BIT_CYCLES/2-1, sample rx_s:
    - 0: go to DATA, cycle_cnt=0, bit_cnt=0.
    - 1: glitch. Pulse frame_err and go to IDLE.
- DATA:
  - cycle_cnt counts 0..BIT_CYCLES-1 and wraps. At the wrap point (BIT_CYCLES-1) the sample is mid-bit.
  - On each sample: shift_reg <= {rx_s, shift_reg[KEY_WIDTH-1:1]}, bit_cnt++.
  - After the sample with bit_cnt = KEY_WIDTH-1: go to STOP.
- STOP:
  - At the next mid-bit sample point:
    - rx_s=1: key_out <= shift_reg and key_valid=1 for exactly one cycle, registered in the same cycle as key_out. Go to IDLE.
    - rx_s=0: frame_err=1 for one cycle; key_out unchanged. Go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then go to IDLE. Prevents a stuck-low line from being taken as back-to-back starts.
- Latency:
  - Let t0 be the cycle in which the falling edge is seen.
  - key_valid asserts (KEY_WIDTH+1)*BIT_CYCLES + BIT_CYCLES/2 cycles after t0.
- Back-to-back frames:
  - A new start bit directly after the stop bit is accepted.
  - IDLE is entered by mid-stop, which is BIT_CYCLES/2 cycles before the next start edge.
- Output properties:
  - key_valid and frame_err are never high in the same cycle.
  - busy=1 in START, DATA, STOP and WAIT_HIGH.
- Widths: bit_cnt is clog2(KEY_WIDTH+1) bits; cycle_cnt is clog2(BIT_CYCLES) bits. No counter overflow is reachable.

Test Plan:
- Reset → all outputs 0.
  - Hold reset=0 for 5 cycles with ant_in toggling.
  - Required: key_out=0, key_valid=0, frame_err=0, busy=0.
- Single frame.
  - Drive a frame of 256'hABCDEF0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF0123456789, BIT_CYCLES=16.
  - Required: one key_valid pulse, key_out equals that value, at cycle t0+4120 (±2 sync cycles), frame_err never 1.
- Back-to-back frames.
  - Drive all-zeros, then 256'h1, with no idle gap.
  - Required: two key_valid pulses 4128 cycles apart; key_out=0, then key_out=1.
- Start glitch.
  - Drive ant_in low for 3 cycles, then high.
  - Required: frame_err pulse once, state returns to IDLE, key_out unchanged, no key_valid.
- Bad stop bit.
  - Drive a valid 256-bit frame with stop=0, then hold the line low 100 cycles, then high.
  - Required: one frame_err pulse, key_out keeps its previous value, busy stays 1 until the line goes high.
  - A following good frame is received correctly.
- Reset mid-frame.
  - Assert reset=0 after 100 data bits, release, then send a full frame 256'h5A…5A.
  - Required: no key_valid from the partial frame; key_out=256'h5A…5A after the new frame.
